// File: rtl/spi_slave_fifo_pkg.sv
// Shared constants for the SPI slave front end of the QOA decoder.
// SPI mode encodings are {CPOL, CPHA}. Default word and FIFO sizes.
package spi_slave_fifo_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/spi_slave_fifo_if.sv
// Decoder-side word streams of the SPI slave.
// Ports: rx_data/rx_valid/rx_ready (slave -> decoder), tx_data/tx_valid/tx_ready (decoder -> slave).
interface spi_slave_fifo_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/spi_slave_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; head reads as 0 while empty.
// Ports: sys_clk, sys_rst, push/push_data, pop/pop_data, full, empty.
module spi_slave_fifo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO fits only if a slot frees this cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// Oversampled SPI slave (any CPOL/CPHA, MSB first) with RX and TX word FIFOs.
// Ports: sys_clk, sys_rst, spi_sclk/cs_n/mosi in, spi_miso/miso_oe out, bus (slave), rx_overflow, tx_underflow, cs_active.
module spi_slave_fifo
    import spi_slave_fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    spi_slave_fifo_if.slave  bus,
    output logic             rx_overflow,
    output logic             tx_underflow,
    output logic             cs_active
);

    localparam logic IDLE = (CPOL != 0);
    localparam logic PH1  = (CPHA != 0);
    localparam int   CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_h;
    logic                   cs_act_d;

    logic              sclk_s;
    logic              mosi_s;
    logic              sclk_chg;
    logic              lead;
    logic              trail;
    logic              sample;
    logic              shift;
    logic              cs_rise;

    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-2:0] rx_shreg;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shreg;
    logic              word_done;
    logic              word_end;
    logic              tx_load;
    logic              alive;

    logic              rx_full;
    logic              rx_empty;
    logic              tx_full;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign cs_active = ~cs_q[SYNC_STAGES-1];
    assign cs_rise   = cs_active & ~cs_act_d;

    // Edges only count inside a frame.
    assign sclk_chg = cs_active & (sclk_s != sclk_h);
    assign lead     = sclk_chg & (sclk_s != IDLE);
    assign trail    = sclk_chg & (sclk_s == IDLE);
    assign sample   = PH1 ? trail : lead;
    assign shift    = PH1 ? lead : trail;

    assign rx_next  = {rx_shreg, mosi_s};
    assign word_end = sample & (bit_cnt == LAST);

    // CPHA=0 must present the MSB before the first edge, so the frame
    // start and the edge after each completed word are load points.
    assign tx_load = PH1 ? (lead & (bit_cnt == '0))
                         : (cs_rise | (shift & word_done));

    assign spi_miso     = tx_shreg[DATA_W-1] & cs_active;
    assign spi_miso_oe  = cs_active;
    assign bus.rx_valid = ~rx_empty;
    assign bus.tx_ready = alive & ~tx_full;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sclk_q   <= {SYNC_STAGES{IDLE}};
            cs_q     <= '1;
            mosi_q   <= '0;
            sclk_h   <= IDLE;
            cs_act_d <= 1'b0;
        end else begin
            sclk_q   <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
            cs_q     <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_h   <= sclk_s;
            cs_act_d <= cs_active;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_cnt      <= '0;
            rx_shreg     <= '0;
            tx_shreg     <= '0;
            word_done    <= 1'b0;
            rx_overflow  <= 1'b0;
            tx_underflow <= 1'b0;
            alive        <= 1'b0;
        end else begin
            alive        <= 1'b1;
            rx_overflow  <= word_end & rx_full & ~bus.rx_ready;
            tx_underflow <= tx_load & tx_empty;
            if (!cs_active) begin
                bit_cnt   <= '0;
                rx_shreg  <= '0;
                tx_shreg  <= '0;
                word_done <= 1'b0;
            end else begin
                if (sample) begin
                    rx_shreg <= rx_next[DATA_W-2:0];
                    bit_cnt  <= word_end ? '0 : bit_cnt + 1'b1;
                end
                if (word_end)   word_done <= 1'b1;
                else if (shift) word_done <= 1'b0;
                if (tx_load)    tx_shreg <= tx_head;
                else if (shift) tx_shreg <= tx_shreg << 1;
            end
        end
    end

    spi_slave_fifo_sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .push     (word_end),
        .push_data(rx_next),
        .pop      (bus.rx_ready),
        .pop_data (bus.rx_data),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    spi_slave_fifo_sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .push     (bus.tx_valid & bus.tx_ready),
        .push_data(bus.tx_data),
        .pop      (tx_load),
        .pop_data (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench: one slave per SPI mode, driven by a behavioural master.
// Ports: none; instance g uses mode g ({CPOL, CPHA}).
module tb_spi_slave_fifo;
    import spi_slave_fifo_pkg::*;

    localparam int H = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       ph      = 1'b0;
    logic       mosi    = 1'b0;
    logic [3:0] cs_n    = 4'hF;

    logic [3:0] miso;
    logic [3:0] oe;
    logic [3:0] ovf;
    logic [3:0] uf;
    logic [3:0] csa;
    logic [3:0] rx_valid;
    logic [3:0] tx_ready;
    logic [3:0] rx_ready = 4'h0;
    logic [3:0] tx_valid = 4'h0;
    logic [7:0] rx_data [4];
    logic [7:0] tx_data [4];

    int uf_cnt  [4] = '{default: 0};
    int ovf_cnt [4] = '{default: 0};
    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 4; g++) begin : inst
        logic sclk;
        assign sclk = (g >= 2) ? ~ph : ph;

        spi_slave_fifo_if #(.DATA_W(8)) bus ();
        assign bus.rx_ready = rx_ready[g];
        assign bus.tx_valid = tx_valid[g];
        assign bus.tx_data  = tx_data[g];
        assign rx_data[g]   = bus.rx_data;
        assign rx_valid[g]  = bus.rx_valid;
        assign tx_ready[g]  = bus.tx_ready;

        spi_slave_fifo #(
            .DATA_W(8), .FIFO_DEPTH(4),
            .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
        ) dut (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .spi_sclk    (sclk),
            .spi_cs_n    (cs_n[g]),
            .spi_mosi    (mosi),
            .spi_miso    (miso[g]),
            .spi_miso_oe (oe[g]),
            .bus         (bus),
            .rx_overflow (ovf[g]),
            .tx_underflow(uf[g]),
            .cs_active   (csa[g])
        );
    end

    always @(posedge sys_clk) begin
        for (int g = 0; g < 4; g++) begin
            if (uf[g])  uf_cnt[g]  <= uf_cnt[g] + 1;
            if (ovf[g]) ovf_cnt[g] <= ovf_cnt[g] + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input int g, input logic [7:0] d);
        tx_data[g]  = d;
        tx_valid[g] = 1'b1;
        cyc(1);
        tx_valid[g] = 1'b0;
    endtask

    task automatic pop_chk(input int g, input string tag, input logic [7:0] d);
        chk({tag, "_valid"}, rx_valid[g], 1'b1);
        chk({tag, "_data"}, rx_data[g], d);
        rx_ready[g] = 1'b1;
        cyc(1);
        rx_ready[g] = 1'b0;
    endtask

    task automatic frame_start(input int g);
        cs_n[g] = 1'b0;
        cyc(2 * H);
    endtask

    task automatic frame_end(input int g);
        ph      = 1'b0;
        cs_n[g] = 1'b1;
        cyc(2 * H);
    endtask

    task automatic xfer(input int m, input logic [7:0] mo,
                        output logic [7:0] mi, input bit last);
        mi = '0;
        if (m % 2 == 0) begin
            for (int i = 7; i >= 0; i--) begin
                mosi = mo[i];
                cyc(H);
                mi[i] = miso[m];
                ph = 1'b1;
                cyc(H);
                if (!(last && i == 0)) ph = 1'b0;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                ph   = 1'b1;
                mosi = mo[i];
                cyc(H);
                mi[i] = miso[m];
                ph = 1'b0;
                cyc(H);
            end
        end
    endtask

    task automatic bits(input int n, input logic [7:0] mo);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = mo[i];
            cyc(H);
            ph = 1'b1;
            cyc(H);
            ph = 1'b0;
        end
        cyc(H);
    endtask

    logic [7:0] mi;
    logic [7:0] rx_w [3];
    logic [7:0] tx_w [3];
    int         base;

    initial begin
        rx_w = '{8'h01, 8'h80, 8'hFF};
        tx_w = '{8'hC3, 8'h5A, 8'h96};
        for (int g = 0; g < 4; g++) tx_data[g] = '0;

        cyc(3);
        chk("rst_rx_valid", rx_valid, 4'h0);
        chk("rst_miso", miso, 4'h0);
        chk("rst_oe", oe, 4'h0);
        chk("rst_cs_active", csa, 4'h0);
        chk("rst_pulses", {uf, ovf}, 8'h00);
        sys_rst = 1'b0;
        cyc(1);
        chk("post_rst_tx_ready", tx_ready, 4'hF);

        base = uf_cnt[0];
        push_tx(0, 8'hA5);
        frame_start(0);
        xfer(MODE0, 8'h3C, mi, 1'b1);
        frame_end(0);
        chk("t1_miso_word", mi, 8'hA5);
        pop_chk(0, "t1_rx", 8'h3C);
        chk("t1_underflow", uf_cnt[0] - base, 0);

        for (int m = 0; m < 4; m++) begin
            base = uf_cnt[m];
            for (int k = 0; k < 3; k++) push_tx(m, tx_w[k]);
            frame_start(m);
            for (int k = 0; k < 3; k++) begin
                xfer(m, rx_w[k], mi, k == 2);
                chk($sformatf("t2_m%0d_miso%0d", m, k), mi, tx_w[k]);
            end
            frame_end(m);
            for (int k = 0; k < 3; k++)
                pop_chk(m, $sformatf("t2_m%0d_rx%0d", m, k), rx_w[k]);
            chk($sformatf("t2_m%0d_empty", m), rx_valid[m], 1'b0);
            chk($sformatf("t2_m%0d_uf", m), uf_cnt[m] - base, 0);
        end

        base = ovf_cnt[0];
        frame_start(0);
        xfer(MODE0, 8'h11, mi, 1'b0);
        xfer(MODE0, 8'h22, mi, 1'b0);
        xfer(MODE0, 8'h33, mi, 1'b0);
        xfer(MODE0, 8'h44, mi, 1'b0);
        xfer(MODE0, 8'h55, mi, 1'b1);
        frame_end(0);
        chk("t3_overflow", ovf_cnt[0] - base, 1);
        pop_chk(0, "t3_rx0", 8'h11);
        pop_chk(0, "t3_rx1", 8'h22);
        pop_chk(0, "t3_rx2", 8'h33);
        pop_chk(0, "t3_rx3", 8'h44);
        chk("t3_empty", rx_valid[0], 1'b0);

        base = uf_cnt[0];
        frame_start(0);
        xfer(MODE0, 8'h77, mi, 1'b1);
        frame_end(0);
        chk("t4_miso_zero", mi, 8'h00);
        chk("t4_underflow", uf_cnt[0] - base, 1);
        pop_chk(0, "t4_rx", 8'h77);

        push_tx(0, 8'hE7);
        frame_start(0);
        bits(5, 8'hF0);
        frame_end(0);
        chk("t5_no_frag", rx_valid[0], 1'b0);
        frame_start(0);
        xfer(MODE0, 8'h5A, mi, 1'b1);
        frame_end(0);
        chk("t5_tx_discarded", mi, 8'h00);
        pop_chk(0, "t5_rx", 8'h5A);
        chk("t5_empty", rx_valid[0], 1'b0);

        frame_start(0);
        xfer(MODE0, 8'h12, mi, 1'b0);
        xfer(MODE0, 8'h34, mi, 1'b1);
        frame_end(0);
        push_tx(0, 8'hAB);
        push_tx(0, 8'hCD);
        chk("t6_pre_rx", rx_valid[0], 1'b1);
        frame_start(0);
        bits(4, 8'hC0);
        sys_rst = 1'b1;
        cyc(1);
        chk("t6_rst_rx_valid", rx_valid[0], 1'b0);
        chk("t6_rst_miso", miso[0], 1'b0);
        chk("t6_rst_oe", oe[0], 1'b0);
        chk("t6_rst_cs_active", csa[0], 1'b0);
        chk("t6_rst_tx_ready", tx_ready[0], 1'b0);
        sys_rst = 1'b0;
        cyc(1);
        chk("t6_tx_ready", tx_ready[0], 1'b1);
        frame_end(0);
        chk("t6_rx_empty", rx_valid[0], 1'b0);
        push_tx(0, 8'h99);
        frame_start(0);
        xfer(MODE0, 8'h6C, mi, 1'b1);
        frame_end(0);
        chk("t6_miso_word", mi, 8'h99);
        pop_chk(0, "t6_rx", 8'h6C);
        chk("t6_final_empty", rx_valid[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
